hw_dispatch_fifo: RTL and testbench

Parametrised hardware dispatcher for the cluster event unit. A master core pushes work items, each tagged with a team mask of target cores. Every targeted core pops each item exactly once, in push order; non-targeted cores skip it. Compared with the previous dispatcher it adds generic data width, single-writer arbitration with grant, entry retirement with full/backpressure, and same-cycle pointer advance on ack.

---
 rtl/hw_dispatch_fifo.sv | 172 +++++++++++++++++
 tb/tb_hw_dispatch_fifo.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_dispatch_fifo.sv
// Multi-consumer dispatch FIFO: one writer per cycle pushes tagged entries, each core pops its own copy in order.
// Optional feature macro HW_DISPATCH_OVF_DROP_EN: pushes while full are dropped and flagged on ovf_err_o instead of stalled.
module hw_dispatch_fifo #(
    parameter int NB_CORES   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NB_CORES-1:0]            pop_req_i,
    input  logic [NB_CORES-1:0]            pop_ack_i,
    output logic [NB_CORES*DATA_WIDTH-1:0] dispatch_value_o,
    output logic [NB_CORES-1:0]            dispatch_event_o,
    input  logic [NB_CORES-1:0]            w_req_i,
    input  logic [NB_CORES*DATA_WIDTH-1:0] w_data_i,
    input  logic [2*NB_CORES-1:0]          reg_sel_i,
    output logic [NB_CORES-1:0]            w_gnt_o,
    output logic                           full_o,
    output logic                           ovf_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);
    localparam logic [1:0]    SEL_PUSH = 2'd0;
    localparam logic [1:0]    SEL_CFG  = 2'd1;

    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [NB_CORES-1:0]   mask_q [FIFO_DEPTH];
    logic [NB_CORES-1:0]   mask_clr [FIFO_DEPTH];
    logic [PW-1:0]         wp_q;
    logic [PW-1:0]         rt_q;
    logic [PW-1:0]         rp_q [NB_CORES];
    logic [AW-1:0]         rd_slot [NB_CORES];
    logic [NB_CORES-1:0]   req_q;
    logic [NB_CORES-1:0]   team_q;

    logic [NB_CORES-1:0]   win_oh;
    logic [1:0]            wr_sel;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_any;
    logic                  is_push;
    logic                  push_stall;
    logic                  wr_fire;
    logic                  push_en;

    logic [NB_CORES-1:0]   not_empty;
    logic [NB_CORES-1:0]   pend;
    logic [NB_CORES-1:0]   ack_fire;
    logic [NB_CORES-1:0]   skip;
    logic                  rt_blocked;
    logic                  retire_en;

    // Write arbitration: isolate the lowest set request bit and mux its select/data
    always_comb begin
        win_oh  = w_req_i & (~w_req_i + NB_CORES'(1));
        wr_sel  = '0;
        wr_data = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            if (win_oh[i]) begin
                wr_sel  = reg_sel_i[2*i +: 2];
                wr_data = w_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wr_any  = |w_req_i;
    assign is_push = wr_any & (wr_sel == SEL_PUSH);
    assign full_o  = (wp_q - rt_q) == DEPTH_P;
    assign w_gnt_o = push_stall ? '0 : win_oh;
    assign wr_fire = wr_any & ~push_stall;
    assign push_en = wr_fire & is_push & ~full_o & (team_q != '0);

`ifdef HW_DISPATCH_OVF_DROP_EN
    localparam logic [1:0] SEL_CLR = 2'd2;
    logic ovf_q;

    assign push_stall = 1'b0;
    assign ovf_err_o  = ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (wr_fire && is_push && full_o) begin
            ovf_q <= 1'b1;
        end else if (wr_fire && wr_sel == SEL_CLR) begin
            ovf_q <= 1'b0;
        end
    end
`else
    assign push_stall = is_push & full_o;
    assign ovf_err_o  = 1'b0;
`endif

    genvar g;
    generate
        for (g = 0; g < NB_CORES; g++) begin : g_core
            assign rd_slot[g]          = rp_q[g][AW-1:0];
            assign not_empty[g]        = rp_q[g] != wp_q;
            assign pend[g]             = mask_q[rd_slot[g]][g];
            assign dispatch_event_o[g] = (req_q[g] | pop_req_i[g]) & not_empty[g] & pend[g];
            assign ack_fire[g]         = pop_ack_i[g] & dispatch_event_o[g];
            assign skip[g]             = not_empty[g] & ~pend[g];
            assign dispatch_value_o[g*DATA_WIDTH +: DATA_WIDTH] = data_q[rd_slot[g]];
        end
    endgenerate

    always_comb begin
        for (int s = 0; s < FIFO_DEPTH; s++) begin
            mask_clr[s] = '0;
        end
        for (int i = 0; i < NB_CORES; i++) begin
            if (ack_fire[i]) begin
                mask_clr[rd_slot[i]][i] = 1'b1;
            end
        end
    end

    // An entry retires only once fully consumed and no core still points at it
    always_comb begin
        rt_blocked = 1'b0;
        for (int i = 0; i < NB_CORES; i++) begin
            if (rp_q[i] == rt_q) begin
                rt_blocked = 1'b1;
            end
        end
    end

    assign retire_en = (rt_q != wp_q) & (mask_q[rt_q[AW-1:0]] == '0) & ~rt_blocked;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q   <= '0;
            rt_q   <= '0;
            req_q  <= '0;
            team_q <= '0;
            for (int s = 0; s < FIFO_DEPTH; s++) begin
                data_q[s] <= '0;
                mask_q[s] <= '0;
            end
            for (int i = 0; i < NB_CORES; i++) begin
                rp_q[i] <= '0;
            end
        end else begin
            for (int s = 0; s < FIFO_DEPTH; s++) begin
                mask_q[s] <= mask_q[s] & ~mask_clr[s];
            end
            // The push slot is never one a core is acking, so this later write cannot collide
            if (push_en) begin
                data_q[wp_q[AW-1:0]] <= wr_data;
                mask_q[wp_q[AW-1:0]] <= team_q;
                wp_q                 <= wp_q + PW'(1);
            end
            if (retire_en) begin
                rt_q <= rt_q + PW'(1);
            end
            if (wr_fire && wr_sel == SEL_CFG) begin
                team_q <= wr_data[NB_CORES-1:0];
            end
            for (int i = 0; i < NB_CORES; i++) begin
                if (ack_fire[i] || skip[i]) begin
                    rp_q[i] <= rp_q[i] + PW'(1);
                end
                if (ack_fire[i]) begin
                    req_q[i] <= 1'b0;
                end else if (pop_req_i[i]) begin
                    req_q[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hw_dispatch_fifo.sv
// Bench for hw_dispatch_fifo: directed scenarios plus randomized traffic against per-core expected-value queues.
module tb_hw_dispatch_fifo;
    localparam int NB    = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NB-1:0]     pop_req_i;
    logic [NB-1:0]     pop_ack_i;
    logic [NB*DW-1:0]  dispatch_value_o;
    logic [NB-1:0]     dispatch_event_o;
    logic [NB-1:0]     w_req_i;
    logic [NB*DW-1:0]  w_data_i;
    logic [2*NB-1:0]   reg_sel_i;
    logic [NB-1:0]     w_gnt_o;
    logic              full_o;
    logic              ovf_err_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [NB][$];
    logic [NB-1:0] team_m;
    int            pushes_m;

    hw_dispatch_fifo #(.NB_CORES(NB), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .pop_req_i        (pop_req_i),
        .pop_ack_i        (pop_ack_i),
        .dispatch_value_o (dispatch_value_o),
        .dispatch_event_o (dispatch_event_o),
        .w_req_i          (w_req_i),
        .w_data_i         (w_data_i),
        .reg_sel_i        (reg_sel_i),
        .w_gnt_o          (w_gnt_o),
        .full_o           (full_o),
        .ovf_err_o        (ovf_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] val(input int c);
        return dispatch_value_o[c*DW +: DW];
    endfunction

    task automatic idle();
        pop_req_i = '0;
        pop_ack_i = '0;
        w_req_i   = '0;
        w_data_i  = '0;
        reg_sel_i = '0;
    endtask

    task automatic set_w(input int c, input logic [1:0] sel, input logic [DW-1:0] d);
        w_req_i[c]          = 1'b1;
        reg_sel_i[2*c +: 2] = sel;
        w_data_i[c*DW +: DW] = d;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
    endtask

    // Single core-0 write that must be granted immediately
    task automatic wr0(input string tag, input logic [1:0] sel, input logic [DW-1:0] d);
        idle();
        set_w(0, sel, d);
        settle();
        check(tag, w_gnt_o, 4'b0001);
        cyc();
        idle();
    endtask

    // Randomized-phase pop bookkeeping: any visible event must carry the next expected value
    task automatic observe_pops();
        for (int c = 0; c < NB; c++) begin
            if (dispatch_event_o[c]) begin
                check("rnd_evt_has_entry", mq[c].size() > 0, 1'b1);
                if (mq[c].size() > 0) begin
                    check("rnd_value", val(c), mq[c][0]);
                    if (pop_ack_i[c]) void'(mq[c].pop_front());
                end
            end
        end
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        cyc();
        cyc();
        settle();
        check("rst_event", dispatch_event_o, 4'b0000);
        check("rst_value", dispatch_value_o, '0);
        check("rst_full", full_o, 1'b0);
        check("rst_ovf", ovf_err_o, 1'b0);
        check("rst_gnt", w_gnt_o, 4'b0000);
        rst_ni = 1'b1;

        // Team 0b0011, push 0xA5
        do_reset();
        wr0("t1_cfg_gnt", 2'd1, 32'h3);
        set_w(0, 2'd0, 32'hA5);
        pop_req_i = 4'b1111;
        settle();
        check("t1_push_gnt", w_gnt_o, 4'b0001);
        check("t1_evt_push_cycle", dispatch_event_o, 4'b0000);
        cyc();
        idle();
        settle();
        check("t1_evt", dispatch_event_o, 4'b0011);
        check("t1_val0", val(0), 32'hA5);
        check("t1_val1", val(1), 32'hA5);
        cyc();
        pop_ack_i = 4'b0011;
        settle();
        check("t1_evt_ack_cycle", dispatch_event_o, 4'b0011);
        cyc();
        idle();
        settle();
        check("t1_evt_after", dispatch_event_o, 4'b0000);
        check("t1_rt_lag", dut.rt_q, 0);
        cyc();
        check("t1_rt_retired", dut.rt_q, 1);

        // Team 0b0001, three back-to-back pushes with core 0 acking every cycle
        do_reset();
        wr0("t2_cfg_gnt", 2'd1, 32'h1);
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 3) set_w(0, 2'd0, 32'h10 + k);
            pop_req_i[0] = 1'b1;
            pop_ack_i[0] = 1'b1;
            settle();
            if (k >= 1 && k <= 3) begin
                check("t2_evt", dispatch_event_o[0], 1'b1);
                check("t2_val", val(0), 32'h10 + k - 1);
            end else begin
                check("t2_evt_idle", dispatch_event_o[0], 1'b0);
            end
            cyc();
        end
        idle();
        cyc();
        check("t2_wp", dut.wp_q, 3);
        check("t2_rp1_skipped", dut.rp_q[1], 3);

        // Fill four entries for core 2 with no pops
        do_reset();
        wr0("t3_cfg_gnt", 2'd1, 32'h4);
        for (int k = 1; k <= 4; k++) begin
            settle();
            check("t3_not_full_yet", full_o, 1'b0);
            wr0("t3_fill_gnt", 2'd0, k);
        end
        settle();
        check("t3_full", full_o, 1'b1);
`ifdef HW_DISPATCH_OVF_DROP_EN
        wr0("t3_drop_gnt", 2'd0, 32'h5);
        settle();
        check("t3_ovf_set", ovf_err_o, 1'b1);
        check("t3_still_full", full_o, 1'b1);
        wr0("t3_clr_gnt", 2'd2, 32'h0);
        settle();
        check("t3_ovf_clr", ovf_err_o, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            idle();
            pop_req_i[2] = 1'b1;
            pop_ack_i[2] = 1'b1;
            settle();
            if (k <= 4) begin
                check("t3_pop_evt", dispatch_event_o[2], 1'b1);
                check("t3_pop_val", val(2), k);
            end else begin
                check("t3_dropped_absent", dispatch_event_o[2], 1'b0);
            end
            cyc();
        end
`else
        idle();
        set_w(0, 2'd0, 32'h5);
        for (int k = 0; k < 2; k++) begin
            settle();
            check("t3_stall_gnt", w_gnt_o, 4'b0000);
            cyc();
        end
        pop_req_i[2] = 1'b1;
        pop_ack_i[2] = 1'b1;
        settle();
        check("t3_ack_evt", dispatch_event_o[2], 1'b1);
        check("t3_ack_val", val(2), 32'h1);
        check("t3_ack_gnt", w_gnt_o, 4'b0000);
        cyc();
        pop_req_i = '0;
        pop_ack_i = '0;
        settle();
        check("t3_full_until_retire", full_o, 1'b1);
        check("t3_gnt_before_retire", w_gnt_o, 4'b0000);
        cyc();
        settle();
        check("t3_full_released", full_o, 1'b0);
        check("t3_late_gnt", w_gnt_o, 4'b0001);
        cyc();
        for (int k = 2; k <= 6; k++) begin
            idle();
            pop_req_i[2] = 1'b1;
            pop_ack_i[2] = 1'b1;
            settle();
            if (k <= 5) begin
                check("t3_pop_evt", dispatch_event_o[2], 1'b1);
                check("t3_pop_val", val(2), k);
            end else begin
                check("t3_drained", dispatch_event_o[2], 1'b0);
            end
            cyc();
        end
`endif

        // Simultaneous pushes from cores 1 and 3
        do_reset();
        wr0("t4_cfg_gnt", 2'd1, 32'h1);
        set_w(1, 2'd0, 32'h31);
        set_w(3, 2'd0, 32'h33);
        settle();
        check("t4_gnt_first", w_gnt_o, 4'b0010);
        cyc();
        w_req_i[1] = 1'b0;
        settle();
        check("t4_gnt_second", w_gnt_o, 4'b1000);
        cyc();
        idle();
        for (int k = 0; k < 2; k++) begin
            pop_req_i[0] = 1'b1;
            pop_ack_i[0] = 1'b1;
            settle();
            check("t4_order", val(0), (k == 0) ? 32'h31 : 32'h33);
            check("t4_evt", dispatch_event_o[0], 1'b1);
            cyc();
        end

        // Wrap-around: ten pushes with continuous pops
        do_reset();
        wr0("t5_cfg_gnt", 2'd1, 32'h1);
        for (int k = 0; k <= 10; k++) begin
            idle();
            if (k < 10) set_w(0, 2'd0, 32'h100 + k);
            pop_req_i[0] = 1'b1;
            pop_ack_i[0] = 1'b1;
            settle();
            check("t5_no_full", full_o, 1'b0);
            if (k >= 1) check("t5_val", val(0), 32'h100 + k - 1);
            cyc();
        end
        idle();
        cyc();
        cyc();
        check("t5_wp", dut.wp_q, 10 % 8);
        check("t5_rt", dut.rt_q, 10 % 8);

        // Reset with three entries pending
        do_reset();
        wr0("t6_cfg_gnt", 2'd1, 32'h1);
        for (int k = 0; k < 3; k++) wr0("t6_push_gnt", 2'd0, 32'h60 + k);
        pop_req_i[0] = 1'b1;
        settle();
        check("t6_pending_evt", dispatch_event_o[0], 1'b1);
        rst_ni = 1'b0;
        settle();
        check("t6_rst_evt", dispatch_event_o, 4'b0000);
        check("t6_rst_value", dispatch_value_o, '0);
        check("t6_rst_full", full_o, 1'b0);
        cyc();
        rst_ni = 1'b1;
        idle();
        wr0("t6_cfg2_gnt", 2'd1, 32'h1);
        wr0("t6_push2_gnt", 2'd0, 32'h77);
        check("t6_wp", dut.wp_q, 1);
        pop_req_i[0] = 1'b1;
        settle();
        check("t6_slot0_val", val(0), 32'h77);
        check("t6_slot0_evt", dispatch_event_o[0], 1'b1);

        // Randomized traffic against per-core expected queues
        do_reset();
        team_m   = '0;
        pushes_m = 0;
        for (int c = 0; c < NB; c++) mq[c].delete();
        for (int n = 0; n < 400; n++) begin
            logic [NB-1:0] exp_g;
            int            win;
            idle();
            if ($urandom_range(0, 1) == 1) w_req_i = NB'($urandom_range(0, 15));
            for (int c = 0; c < NB; c++) begin
                logic [1:0] s;
                s = 2'($urandom_range(0, 3));
                if (full_o && s == 2'd0) s = 2'd3;
                reg_sel_i[2*c +: 2]  = s;
                w_data_i[c*DW +: DW] = $urandom;
            end
            pop_req_i = NB'($urandom_range(0, 15));
            pop_ack_i = NB'($urandom_range(0, 15));
            settle();
            exp_g = '0;
            win   = -1;
            for (int c = 0; c < NB; c++) begin
                if (w_req_i[c] && win < 0) begin
                    win      = c;
                    exp_g[c] = 1'b1;
                end
            end
            check("rnd_gnt", w_gnt_o, exp_g);
            observe_pops();
            if (win >= 0) begin
                if (reg_sel_i[2*win +: 2] == 2'd0 && team_m != '0) begin
                    for (int c = 0; c < NB; c++)
                        if (team_m[c]) mq[c].push_back(w_data_i[win*DW +: DW]);
                    pushes_m++;
                end else if (reg_sel_i[2*win +: 2] == 2'd1) begin
                    team_m = w_data_i[win*DW +: NB];
                end
            end
            cyc();
        end
        for (int n = 0; n < 60; n++) begin
            idle();
            pop_req_i = '1;
            pop_ack_i = '1;
            settle();
            observe_pops();
            cyc();
        end
        idle();
        pop_req_i = '1;
        settle();
        for (int c = 0; c < NB; c++) check("rnd_queue_drained", mq[c].size(), 0);
        check("rnd_evt_idle", dispatch_event_o, 4'b0000);
        check("rnd_full_idle", full_o, 1'b0);
        check("rnd_wp", dut.wp_q, pushes_m % 8);
        check("rnd_rt", dut.rt_q, pushes_m % 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
